// File: rtl/adder_slice_sched_if.sv
// Bundle of request, response and slice-side signals for adder_slice_sched.
// The DUT uses the slave modport; the requesters, response consumer and slice model use the master modport.
interface adder_slice_sched_if #(
    parameter int WIDTH = 12,
    parameter int NREQ  = 2,
    parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic [2:0]            sl_a;
    logic [2:0]            sl_b;
    logic                  sl_cin;
    logic [2:0]            sl_sum;
    logic                  sl_cout;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready, sl_sum, sl_cout,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, sl_a, sl_b, sl_cin
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready, sl_sum, sl_cout,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, sl_a, sl_b, sl_cin
    );
endinterface

// File: rtl/adder_slice_sched.sv
// Round-robin scheduler that time-shares one external 3-bit add slice among NREQ requesters,
// running each WIDTH-bit add LSB-first, one chunk per cycle, with the carry chained in a register.
module adder_slice_sched #(
    parameter int WIDTH = 12,
    parameter int NREQ  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_slice_sched_if.slave bus
);
    localparam int NCHUNK = WIDTH / 3;
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   rr_q;
    logic [CW-1:0]    chunk_q;
    logic             carry_q;
    logic             rsp_valid_q;
    logic             rsp_cout_q;
    logic [2:0]       sl_a_q;
    logic [2:0]       sl_b_q;

    logic [IDW-1:0]   grant_s;
    logic             any_s;
    logic [NREQ-1:0]  req_ready_s;
    logic [IDW-1:0]   rr_next_s;
    logic             last_chunk_s;

    function automatic logic [2:0] chunk_of(input logic [WIDTH-1:0] v, input int k);
        return v[3*k +: 3];
    endfunction

    // Round-robin search: first valid requester at or above the rr pointer, wrapping.
    always_comb begin
        grant_s = {IDW{1'b0}};
        any_s   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any_s && bus.req_valid[(int'(rr_q) + i) % NREQ]) begin
                any_s   = 1'b1;
                grant_s = IDW'((int'(rr_q) + i) % NREQ);
            end else begin
                any_s   = any_s;
            end
        end
    end

    // Grant strobe, only offered while idle and out of reset.
    always_comb begin
        req_ready_s = {NREQ{1'b0}};
        if (state_q == IDLE && any_s && rst_n) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = {NREQ{1'b0}};
        end
    end

    // Pointer moves just past the requester that was served.
    always_comb begin
        rr_next_s    = (id_q == IDW'(NREQ - 1)) ? {IDW{1'b0}} : id_q + IDW'(1);
        last_chunk_s = (chunk_q == CW'(NCHUNK - 1));
    end

    // Scheduler FSM; slice operands are registered one edge ahead so they line up with chunk_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            id_q        <= {IDW{1'b0}};
            rr_q        <= {IDW{1'b0}};
            chunk_q     <= {CW{1'b0}};
            carry_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_cout_q  <= 1'b0;
            sl_a_q      <= 3'd0;
            sl_b_q      <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_s) begin
                        a_q     <= bus.req_a[int'(grant_s)*WIDTH +: WIDTH];
                        b_q     <= bus.req_b[int'(grant_s)*WIDTH +: WIDTH];
                        id_q    <= grant_s;
                        carry_q <= bus.req_cin[grant_s];
                        chunk_q <= {CW{1'b0}};
                        sl_a_q  <= chunk_of(bus.req_a[int'(grant_s)*WIDTH +: WIDTH], 0);
                        sl_b_q  <= chunk_of(bus.req_b[int'(grant_s)*WIDTH +: WIDTH], 0);
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[3*int'(chunk_q) +: 3] <= bus.sl_sum;
                    if (last_chunk_s) begin
                        rsp_cout_q  <= bus.sl_cout;
                        rsp_valid_q <= 1'b1;
                        carry_q     <= 1'b0;
                        chunk_q     <= {CW{1'b0}};
                        sl_a_q      <= 3'd0;
                        sl_b_q      <= 3'd0;
                        state_q     <= RESP;
                    end else begin
                        carry_q     <= bus.sl_cout;
                        chunk_q     <= chunk_q + CW'(1);
                        sl_a_q      <= chunk_of(a_q, int'(chunk_q) + 1);
                        sl_b_q      <= chunk_of(b_q, int'(chunk_q) + 1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rr_q        <= rr_next_s;
                        state_q     <= IDLE;
                    end else begin
                        state_q     <= RESP;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = rsp_cout_q;
    assign bus.sl_a      = sl_a_q;
    assign bus.sl_b      = sl_b_q;
    assign bus.sl_cin    = carry_q;
endmodule

// File: tb/tb_adder_slice_sched.sv
// Bench for adder_slice_sched: transaction-level model checked every cycle, directed cases, random traffic.
module tb_adder_slice_sched;
    localparam int W      = 12;
    localparam int N      = 2;
    localparam int NCHUNK = W / 3;

    logic clk;
    logic rst_n;

    adder_slice_sched_if #(.WIDTH(W), .NREQ(N)) bus ();

    adder_slice_sched #(.WIDTH(W), .NREQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Slice: a plain 3-bit adder
    assign {bus.sl_cout, bus.sl_sum} = {1'b0, bus.sl_a} + {1'b0, bus.sl_b} + {3'b000, bus.sl_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model state
    logic          m_busy = 1'b0;
    int            m_age  = 0;
    int            m_rr   = 0;
    int            m_id   = 0;
    logic [W-1:0]  m_a, m_b;
    logic          m_cin;
    logic [W:0]    m_res;
    int            m_acc_cyc = 0;
    logic          m_seen = 1'b0;
    int            cyc = 0;
    logic [N-1:0]  grant_seen = '0;
    int            ndone [N];

    int            grants[$];
    int            d_id[$];
    int            d_sum[$];
    int            d_cout[$];
    int            lat_q[$];

    logic [N-1:0]  e_ready;
    logic [2:0]    e_sla, e_slb;
    logic          e_slc, e_rv;
    int            g, k;
    longint        msk;

    initial begin
        for (int i = 0; i < N; i++) ndone[i] = 0;
    end

    // Per-cycle comparison against the model, then advance the model across the coming edge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_rsp_sum", bus.rsp_sum, 0);
            chk("rst_rsp_cout", bus.rsp_cout, 0);
            chk("rst_sl", {bus.sl_a, bus.sl_b, bus.sl_cin}, 0);
            m_busy = 1'b0;
            m_rr   = 0;
            grant_seen = '0;
        end else begin
            e_ready = '0; e_sla = 3'd0; e_slb = 3'd0; e_slc = 1'b0; e_rv = 1'b0; g = -1;
            if (!m_busy) begin
                for (int off = N - 1; off >= 0; off--)
                    if (bus.req_valid[(m_rr + off) % N]) g = (m_rr + off) % N;
                if (g >= 0) e_ready[g] = 1'b1;
            end else if (m_age <= NCHUNK) begin
                k     = m_age - 1;
                msk   = (64'd1 << (3 * k)) - 64'd1;
                e_sla = 3'((longint'(m_a) >> (3 * k)) & 64'd7);
                e_slb = 3'((longint'(m_b) >> (3 * k)) & 64'd7);
                e_slc = 1'(((longint'(m_a) & msk) + (longint'(m_b) & msk) + longint'(m_cin)) >> (3 * k));
            end else begin
                e_rv = 1'b1;
            end
            chk("req_ready", bus.req_ready, e_ready);
            chk("rsp_valid", bus.rsp_valid, e_rv);
            chk("sl_a", bus.sl_a, e_sla);
            chk("sl_b", bus.sl_b, e_slb);
            chk("sl_cin", bus.sl_cin, e_slc);
            if (e_rv) begin
                chk("rsp_sum", bus.rsp_sum, m_res[W-1:0]);
                chk("rsp_cout", bus.rsp_cout, m_res[W]);
                chk("rsp_id", bus.rsp_id, m_id);
                if (!m_seen) begin
                    lat_q.push_back(cyc - m_acc_cyc);
                    m_seen = 1'b1;
                end
            end
            grant_seen = bus.req_ready;
            if (!m_busy) begin
                if (g >= 0) begin
                    m_busy = 1'b1; m_age = 1; m_id = g; m_acc_cyc = cyc; m_seen = 1'b0;
                    m_a   = bus.req_a[g*W +: W];
                    m_b   = bus.req_b[g*W +: W];
                    m_cin = bus.req_cin[g];
                    m_res = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
                    grants.push_back(g);
                end
            end else if (m_age <= NCHUNK) begin
                m_age++;
            end else if (bus.rsp_ready) begin
                d_id.push_back(int'(bus.rsp_id));
                d_sum.push_back(int'(bus.rsp_sum));
                d_cout.push_back(int'(bus.rsp_cout));
                ndone[m_id]++;
                m_busy = 1'b0;
                m_rr   = (m_id + 1) % N;
            end
        end
    end

    // Present one request, wait for its grant, then withdraw it (entered just after a rising edge)
    task automatic issue(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bit ok;
        ok = 1'b0;
        bus.req_a[id*W +: W] = a;
        bus.req_b[id*W +: W] = b;
        bus.req_cin[id]      = cin;
        bus.req_valid[id]    = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready[id]) ok = 1'b1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int n0);
        int i;
        i = 0;
        while (d_sum.size() <= n0 && i < 100) begin
            @(posedge clk); #1; i++;
        end
        if (d_sum.size() <= n0) chk("rsp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (m_busy && i < 100) begin
            @(posedge clk); #1; i++;
        end
        if (m_busy) chk("idle_timeout", 0, 1);
    endtask

    int n0, gi, tgt, cycles, total;

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain add, latency pinned
        n0 = d_sum.size();
        issue(0, 12'h123, 12'h456, 1'b0);
        wait_rsp(n0);
        if (d_sum.size() > n0) begin
            chk("t1_sum", d_sum[n0], 32'h579);
            chk("t1_cout", d_cout[n0], 0);
            chk("t1_id", d_id[n0], 0);
            chk("t1_latency", lat_q[lat_q.size()-1], 5);
        end

        // Carry through every chunk
        n0 = d_sum.size();
        issue(1, 12'hFFF, 12'h000, 1'b1);
        wait_rsp(n0);
        if (d_sum.size() > n0) begin
            chk("t2_sum", d_sum[n0], 32'h000);
            chk("t2_cout", d_cout[n0], 1);
            chk("t2_id", d_id[n0], 1);
        end

        // Both requesters hold valid: grants must alternate starting at 0
        gi = grants.size();
        bus.req_a = {12'h3C5, 12'h1A7}; bus.req_b = {12'h0F0, 12'hE19}; bus.req_cin = 2'b10;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 200 && grants.size() < gi + 4; i++) begin
            @(posedge clk); #1;
        end
        bus.req_valid = 2'b00;
        if (grants.size() >= gi + 4) begin
            for (int i = 0; i < 4; i++) chk("t3_grant_order", grants[gi+i], i % 2);
        end else begin
            chk("t3_grant_timeout", grants.size(), gi + 4);
        end
        wait_idle();

        // Response held under back-pressure while another requester waits
        bus.rsp_ready = 1'b0;
        n0 = d_sum.size();
        issue(0, 12'h7A5, 12'h15B, 1'b1);
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        bus.req_a[W +: W] = 12'h001; bus.req_b[W +: W] = 12'h002; bus.req_cin[1] = 1'b0;
        bus.req_valid[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t4_valid_held", bus.rsp_valid, 1);
        chk("t4_no_handshake", d_sum.size(), n0);
        bus.rsp_ready = 1'b1;
        gi = grants.size();
        wait_rsp(n0);
        if (d_sum.size() > n0) begin
            chk("t4_sum", d_sum[n0], 32'h901);
            chk("t4_id", d_id[n0], 0);
        end
        for (int i = 0; i < 20 && grants.size() <= gi; i++) begin
            @(posedge clk); #1;
        end
        bus.req_valid[1] = 1'b0;
        wait_idle();

        // Reset during chunk 2: transaction dropped, next one clean
        n0 = d_sum.size();
        issue(0, 12'hABC, 12'h321, 1'b1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t5_no_response", d_sum.size(), n0);
        issue(1, 12'h0AB, 12'h0CD, 1'b1);
        wait_rsp(n0);
        if (d_sum.size() > n0) begin
            chk("t5_sum", d_sum[n0], 32'h179);
            chk("t5_id", d_id[n0], 1);
        end
        wait_idle();

        // Random traffic
        tgt = d_sum.size() + 2000;
        cycles = 0;
        while (d_sum.size() < tgt && cycles < 60000) begin
            @(posedge clk); #1;
            cycles++;
            bus.rsp_ready = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && grant_seen[i]) begin
                    bus.req_valid[i] = 1'b0;
                    grant_seen[i]    = 1'b0;
                end else if (bus.req_valid[i] && ($urandom % 16) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
                if (!bus.req_valid[i] && ($urandom % 3) == 0) begin
                    bus.req_a[i*W +: W] = W'($urandom);
                    bus.req_b[i*W +: W] = W'($urandom);
                    bus.req_cin[i]      = 1'($urandom);
                    bus.req_valid[i]    = 1'b1;
                end
            end
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        chk("t6_txn_count", (d_sum.size() >= tgt), 1);
        total = 0;
        for (int i = 0; i < N; i++) begin
            chk("t6_requester_served", (ndone[i] > 100), 1);
            total += ndone[i];
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
